// File: rtl/ramio_arbiter.sv
// rtl/ramio_arbiter.sv - two-port round-robin arbiter/sequencer in front of the RAM/UART/LED I/O block
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   pN_req                   request, held high by the requester until pN_done
//   pN_write_type            00 none, 01 byte, 10 half, 11 word
//   pN_read_type             000 none; bit2 sign-extend; [1:0] 01 byte, 10 half, 11 word
//   pN_address, pN_data_in   byte address and write data
//   pN_gnt                   pulse in the IDLE cycle where the request fields are latched
//   pN_done, pN_err          completion pulse; err marks a rejected or timed-out request
//   pN_data_out              read result, held until the next read completes on that port
//   m_*                      shared interface to the I/O block
//   owner                    port of the current or last transaction
module ramio_arbiter #(
   parameter int ADDRESS_BITWIDTH = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        p0_req,
   input  logic [1:0]                  p0_write_type,
   input  logic [2:0]                  p0_read_type,
   input  logic [ADDRESS_BITWIDTH-1:0] p0_address,
   input  logic [DATA_WIDTH-1:0]       p0_data_in,
   output logic                        p0_gnt,
   output logic                        p0_done,
   output logic                        p0_err,
   output logic [DATA_WIDTH-1:0]       p0_data_out,
   input  logic                        p1_req,
   input  logic [1:0]                  p1_write_type,
   input  logic [2:0]                  p1_read_type,
   input  logic [ADDRESS_BITWIDTH-1:0] p1_address,
   input  logic [DATA_WIDTH-1:0]       p1_data_in,
   output logic                        p1_gnt,
   output logic                        p1_done,
   output logic                        p1_err,
   output logic [DATA_WIDTH-1:0]       p1_data_out,
   output logic                        m_enable,
   output logic [1:0]                  m_write_type,
   output logic [2:0]                  m_read_type,
   output logic [ADDRESS_BITWIDTH-1:0] m_address,
   output logic [DATA_WIDTH-1:0]       m_data_in,
   input  logic [DATA_WIDTH-1:0]       m_data_out,
   input  logic                        m_data_out_ready,
   input  logic                        m_busy,
   output logic                        owner
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]                  state;
   logic [1:0]                  lat_wt;
   logic [2:0]                  lat_rt;
   logic [ADDRESS_BITWIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0]       lat_data;
   logic                        last_owner;
   logic                        resp_err;
   logic [CNT_W-1:0]            cnt;

   logic                        sel_any;
   logic                        sel;
   logic [1:0]                  sel_wt;
   logic [2:0]                  sel_rt;
   logic [ADDRESS_BITWIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]       sel_data;
   logic [1:0]                  sel_size;
   logic                        sel_bad;
   logic                        grant;
   logic                        active;
   logic                        is_read;
   logic                        xfer_done;
   logic                        timed_out;

   // Port selection and request validation, evaluated on the live request
   // fields in IDLE so the verdict is latched together with the fields.
   always_comb begin
      sel_any = p0_req | p1_req;
      if (p0_req && p1_req)
         sel = ~last_owner;
      else
         sel = p1_req;
      sel_wt   = sel ? p1_write_type : p0_write_type;
      sel_rt   = sel ? p1_read_type  : p0_read_type;
      sel_addr = sel ? p1_address    : p0_address;
      sel_data = sel ? p1_data_in    : p0_data_in;
      sel_size = (sel_wt != 2'b00) ? sel_wt : sel_rt[1:0];
      sel_bad  = ((sel_wt != 2'b00) && (sel_rt != 3'b000))
              || ((sel_wt == 2'b00) && (sel_rt == 3'b000))
              || ((sel_size == 2'b10) && sel_addr[0])
              || ((sel_size == 2'b11) && (sel_addr[1:0] != 2'b00));
   end

   // gnt is combinational so it coincides with the cycle the fields are
   // sampled; rst gating keeps it quiet while reset is held.
   assign grant  = !rst && (state == ST_IDLE) && sel_any;
   assign p0_gnt = grant & ~sel;
   assign p1_gnt = grant &  sel;

   assign p0_done = (state == ST_RESP) && !owner;
   assign p1_done = (state == ST_RESP) &&  owner;
   assign p0_err  = p0_done && resp_err;
   assign p1_err  = p1_done && resp_err;

   // m_* are decoded from state so an asynchronous reset clears them at once.
   assign active       = (state == ST_ISSUE) || (state == ST_WAIT);
   assign m_enable     = active;
   assign m_write_type = active ? lat_wt   : '0;
   assign m_read_type  = active ? lat_rt   : '0;
   assign m_address    = active ? lat_addr : '0;
   assign m_data_in    = active ? lat_data : '0;

   assign is_read   = (lat_rt != 3'b000);
   assign xfer_done = !m_busy && (!is_read || m_data_out_ready);
   assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         lat_wt      <= '0;
         lat_rt      <= '0;
         lat_addr    <= '0;
         lat_data    <= '0;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         resp_err    <= 1'b0;
         cnt         <= '0;
         p0_data_out <= '0;
         p1_data_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sel_any) begin
                  lat_wt     <= sel_wt;
                  lat_rt     <= sel_rt;
                  lat_addr   <= sel_addr;
                  lat_data   <= sel_data;
                  owner      <= sel;
                  last_owner <= sel;
                  resp_err   <= sel_bad;
                  state      <= sel_bad ? ST_RESP : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (xfer_done) begin
                  if (is_read) begin
                     if (owner)
                        p1_data_out <= m_data_out;
                     else
                        p0_data_out <= m_data_out;
                  end
                  resp_err <= 1'b0;
                  state    <= ST_RESP;
               end else if (timed_out) begin
                  resp_err <= 1'b1;
                  state    <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb/tb_ramio_arbiter.sv - scoreboard bench for ramio_arbiter
module tb_ramio_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req, p1_req;
   logic [1:0]    p0_write_type, p1_write_type;
   logic [2:0]    p0_read_type, p1_read_type;
   logic [AW-1:0] p0_address, p1_address;
   logic [DW-1:0] p0_data_in, p1_data_in;
   logic          p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
   logic [DW-1:0] p0_data_out, p1_data_out;
   logic          m_enable;
   logic [1:0]    m_write_type;
   logic [2:0]    m_read_type;
   logic [AW-1:0] m_address;
   logic [DW-1:0] m_data_in;
   logic [DW-1:0] m_data_out;
   logic          m_data_out_ready;
   logic          m_busy;
   logic          owner;

   typedef struct packed {
      logic        port;
      logic        err;
      logic [31:0] data;
   } done_t;

   done_t       exp_done[$];
   logic        exp_gnt[$];
   logic [31:0] model_dout [2];
   logic        pending [2];
   int          checks = 0;
   int          errors = 0;
   int          done_count = 0;
   bit          auto_drop = 1'b1;
   bit          mem_mode = 1'b1;
   logic        prev_gnt_valid = 1'b0;
   logic        prev_gnt_port = 1'b0;

   logic        rj_port [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [1:0]  rj_wt   [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00};
   logic [2:0]  rj_rt   [5] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b110};
   logic [31:0] rj_addr [5] = '{32'h3, 32'h40, 32'h2, 32'h0, 32'h1};

   always #5 clk = ~clk;

   ramio_arbiter #(
      .ADDRESS_BITWIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_write_type(p0_write_type), .p0_read_type(p0_read_type),
      .p0_address(p0_address), .p0_data_in(p0_data_in),
      .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_data_out(p0_data_out),
      .p1_req(p1_req), .p1_write_type(p1_write_type), .p1_read_type(p1_read_type),
      .p1_address(p1_address), .p1_data_in(p1_data_in),
      .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_data_out(p1_data_out),
      .m_enable(m_enable), .m_write_type(m_write_type), .m_read_type(m_read_type),
      .m_address(m_address), .m_data_in(m_data_in), .m_data_out(m_data_out),
      .m_data_out_ready(m_data_out_ready), .m_busy(m_busy), .owner(owner)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0000};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic port, input logic [1:0] wt, input logic [2:0] rt,
                        input logic [31:0] addr, input logic [31:0] data);
      if (port) begin
         p1_req = 1'b1; p1_write_type = wt; p1_read_type = rt;
         p1_address = addr; p1_data_in = data;
      end else begin
         p0_req = 1'b1; p0_write_type = wt; p0_read_type = rt;
         p0_address = addr; p0_data_in = data;
      end
   endtask

   task automatic expect_txn(input logic port, input logic err, input logic [31:0] data);
      done_t e;
      exp_gnt.push_back(port);
      e.port = port;
      e.err  = err;
      e.data = data;
      exp_done.push_back(e);
   endtask

   // Observe one cycle at the falling edge: grants and completions are
   // matched against the scoreboard queues; the bench also plays memory.
   task automatic sample();
      logic  g;
      logic  d;
      done_t e;
      @(negedge clk);
      if (prev_gnt_valid) begin
         check("owner_after_gnt", owner, prev_gnt_port);
         prev_gnt_valid = 1'b0;
      end
      if (p0_gnt || p1_gnt) begin
         g = p1_gnt;
         check("gnt_onehot", {p0_gnt, p1_gnt}, g ? 2'b01 : 2'b10);
         check("gnt_expected", exp_gnt.size() > 0, 1);
         if (exp_gnt.size() > 0) check("gnt_port", g, exp_gnt.pop_front());
         pending[g]     = 1'b1;
         prev_gnt_valid = 1'b1;
         prev_gnt_port  = g;
      end
      if (p0_done || p1_done) begin
         d = p1_done;
         check("done_onehot", {p0_done, p1_done}, d ? 2'b01 : 2'b10);
         check("done_after_gnt", pending[d], 1);
         pending[d] = 1'b0;
         check("done_expected", exp_done.size() > 0, 1);
         if (exp_done.size() > 0) begin
            e = exp_done.pop_front();
            check("done_port", d, e.port);
            check("done_err", d ? p1_err : p0_err, e.err);
            check("done_data", d ? p1_data_out : p0_data_out, e.data);
            model_dout[e.port] = e.data;
         end
         done_count++;
         if (auto_drop) begin
            if (d) p1_req = 1'b0;
            else   p0_req = 1'b0;
         end
      end else begin
         check("err_without_done", {p0_err, p1_err}, 2'b00);
      end
      if (mem_mode) m_data_out = mem_val(m_address);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int target, input int budget);
      int start;
      int n;
      start = done_count;
      n = 0;
      while ((done_count - start) < target && n < budget) begin
         sample();
         advance();
         n++;
      end
      check("run_budget", (done_count - start) >= target, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      p0_req = 0; p0_write_type = 0; p0_read_type = 0; p0_address = 0; p0_data_in = 0;
      p1_req = 0; p1_write_type = 0; p1_read_type = 0; p1_address = 0; p1_data_in = 0;
      m_busy = 0; m_data_out_ready = 0; m_data_out = 0;
      model_dout[0] = 0; model_dout[1] = 0;
      pending[0] = 0; pending[1] = 0;

      // Reset state, with a request present that must not be granted
      advance();
      drive(0, 2'b00, 3'b011, 32'h0, 32'h0);
      sample();
      check("rst_gnt_done_err", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err}, 6'b0);
      check("rst_m_ctrl", {m_enable, m_write_type, m_read_type}, 6'b0);
      check("rst_m_addr", m_address, 0);
      check("rst_m_din", m_data_in, 0);
      check("rst_dout", {p0_data_out, p1_data_out}, 64'h0);
      check("rst_owner", owner, 0);
      p0_req = 1'b0;
      rst = 1'b0;
      advance();

      // Contention from reset: strict alternation starting with p0
      m_busy = 0; m_data_out_ready = 1; auto_drop = 0;
      drive(0, 2'b00, 3'b011, 32'h100, 32'h0);
      drive(1, 2'b00, 3'b011, 32'h200, 32'h0);
      expect_txn(0, 0, mem_val(32'h100));
      expect_txn(1, 0, mem_val(32'h200));
      expect_txn(0, 0, mem_val(32'h100));
      expect_txn(1, 0, mem_val(32'h200));
      run_until(4, 40);
      p0_req = 0; p1_req = 0; auto_drop = 1;
      advance();

      // Single read with cycle-exact latency
      mem_mode = 0; m_data_out_ready = 0; m_data_out = 0;
      drive(0, 2'b00, 3'b111, 32'h10, 32'h0);
      expect_txn(0, 0, 32'hDEADBEEF);
      sample();
      check("rd_c0_gnt", p0_gnt, 1);
      check("rd_c0_men", m_enable, 0);
      advance();
      sample();
      check("rd_c1_m", {m_enable, m_read_type, m_write_type}, {1'b1, 3'b111, 2'b00});
      check("rd_c1_addr", m_address, 32'h10);
      advance();
      m_data_out_ready = 1; m_data_out = 32'hDEADBEEF;
      sample();
      check("rd_c2_men", m_enable, 1);
      check("rd_c2_nodone", p0_done, 0);
      advance();
      sample();
      check("rd_c3_done", {p0_done, p0_err}, 2'b10);
      check("rd_c3_men", m_enable, 0);
      advance();

      // Cache miss write; fields changed after gnt must not leak through
      m_busy = 1; m_data_out_ready = 0;
      drive(1, 2'b11, 3'b000, 32'h20, 32'h12345678);
      expect_txn(1, 0, model_dout[1]);
      sample();
      check("miss_gnt", p1_gnt, 1);
      advance();
      p1_address = 32'hFFFF_FFF0; p1_data_in = 32'h0; p1_write_type = 2'b00;
      sample();
      check("miss_issue_m", {m_enable, m_write_type, m_read_type}, 6'b1_11_000);
      check("miss_issue_addr", m_address, 32'h20);
      advance();
      for (int i = 0; i < 10; i++) begin
         sample();
         check("miss_wait_m", {m_enable, m_write_type, m_read_type}, 6'b1_11_000);
         check("miss_wait_addr", m_address, 32'h20);
         check("miss_wait_din", m_data_in, 32'h12345678);
         check("miss_wait_nodone", p1_done, 0);
         advance();
      end
      m_busy = 0;
      sample();
      check("miss_last_wait_din", m_data_in, 32'h12345678);
      check("miss_last_wait_nodone", p1_done, 0);
      advance();
      sample();
      check("miss_resp_done", {p1_done, p1_err}, 2'b10);
      check("miss_resp_m", {m_enable, m_write_type, m_read_type}, 6'b0);
      check("miss_resp_addr_din", {m_address, m_data_in}, 64'h0);
      advance();

      // Rejections: gnt then done+err next cycle, never reaching the I/O block
      for (int i = 0; i < 5; i++) begin
         drive(rj_port[i], rj_wt[i], rj_rt[i], rj_addr[i], 32'hA5A5A5A5);
         expect_txn(rj_port[i], 1, model_dout[rj_port[i]]);
         sample();
         check("rej_gnt", rj_port[i] ? p1_gnt : p0_gnt, 1);
         check("rej_c0_men", m_enable, 0);
         advance();
         sample();
         check("rej_done_err", rj_port[i] ? {p1_done, p1_err} : {p0_done, p0_err}, 2'b11);
         check("rej_c1_men", m_enable, 0);
         advance();
      end

      // Timeout: busy stuck, abort exactly TO cycles after entering WAIT
      mem_mode = 1; m_busy = 1; m_data_out_ready = 1;
      drive(0, 2'b00, 3'b011, 32'h80, 32'h0);
      expect_txn(0, 1, model_dout[0]);
      sample();
      check("to_gnt", p0_gnt, 1);
      advance();
      sample();
      check("to_issue_men", m_enable, 1);
      advance();
      for (int i = 0; i < TO; i++) begin
         sample();
         check("to_wait_nodone", p0_done, 0);
         check("to_wait_men", m_enable, 1);
         advance();
      end
      sample();
      check("to_done_err", {p0_done, p0_err}, 2'b11);
      check("to_resp_men", m_enable, 0);
      advance();
      m_busy = 0;
      drive(1, 2'b00, 3'b011, 32'h84, 32'h0);
      expect_txn(1, 0, mem_val(32'h84));
      run_until(1, 10);

      // Reset in the middle of WAIT drops the transaction silently
      m_busy = 1;
      drive(1, 2'b00, 3'b011, 32'h90, 32'h0);
      exp_gnt.push_back(1'b1);
      sample();
      advance();
      sample();
      advance();
      sample();
      check("rstw_pre_men", m_enable, 1);
      rst = 1'b1;
      #1;
      check("rstw_async_men", m_enable, 0);
      check("rstw_async_addr", m_address, 0);
      check("rstw_async_done", {p0_done, p1_done, p0_err, p1_err}, 4'b0);
      p1_req = 0;
      pending[0] = 0; pending[1] = 0;
      model_dout[0] = 0; model_dout[1] = 0;
      prev_gnt_valid = 0;
      advance();
      sample();
      check("rstw_held_done", {p0_done, p1_done}, 2'b00);
      check("rstw_held_dout", {p0_data_out, p1_data_out}, 64'h0);
      advance();
      rst = 1'b0;
      m_busy = 0;
      advance();
      drive(0, 2'b00, 3'b011, 32'hA0, 32'h0);
      drive(1, 2'b00, 3'b011, 32'hA4, 32'h0);
      expect_txn(0, 0, mem_val(32'hA0));
      expect_txn(1, 0, mem_val(32'hA4));
      run_until(2, 20);
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end
      check("gnt_queue_empty", exp_gnt.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
